ahb2apb_bridge: RTL and testbench

AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

---
 rtl/ahb_apb_pkg.sv | 29 ++
 rtl/apb_wait_timer.sv | 32 +++
 rtl/ahb2apb_bridge.sv | 125 ++++++++++++
 tb/tb_ahb2apb_bridge.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the AHB-to-APB bridge: AHB transfer/response codes and FSM states.
package ahb_apb_pkg;

    // AHB HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Bridge FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WLATCH = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } bridge_state_e;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
    function automatic logic is_active_trans(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts APB wait cycles in ACCESS and flags the cycle in which the wait limit is hit.
module apb_wait_timer
    import ahb_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Count value seen during the TIMEOUT-th wait cycle.
    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Wait counter: cleared on ACCESS entry, saturates so it never wraps when TIMEOUT is 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // Fires when this wait cycle is the TIMEOUT-th one and pready is still low.
    assign timeout = (TIMEOUT != 0) && count_en && (count == LIMIT);

endmodule

// File: rtl/ahb2apb_bridge.sv
// Single-outstanding AHB-lite to APB bridge with registered outputs and APB wait timeout.
module ahb2apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [1:0]        htrans,
    input  logic              hready,
    input  logic [DATA_W-1:0] hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    bridge_state_e state;
    logic          accept;
    logic          timer_clear;
    logic          timer_en;
    logic          timeout;

    // Transfers are only taken in IDLE; ERR1/ERR2 silently drop anything presented.
    assign accept      = (state == IDLE) && hsel && hready && is_active_trans(htrans);
    assign timer_clear = (state == SETUP);
    assign timer_en    = (state == ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (hclk),
        .rst      (hreset),
        .clear    (timer_clear),
        .count_en (timer_en),
        .timeout  (timeout)
    );

    // FSM and all bus outputs; outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= IDLE;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            hrdata    <= '0;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        paddr     <= haddr;
                        pwrite    <= hwrite;
                        hreadyout <= 1'b0;
                        if (hwrite) begin
                            // Write data arrives one cycle later, in the AHB data phase.
                            state <= WLATCH;
                        end else begin
                            state <= SETUP;
                            psel  <= 1'b1;
                        end
                    end
                end
                WLATCH: begin
                    pwdata <= hwdata;
                    psel   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pslverr) begin
                            state <= ERR1;
                            hresp <= HRESP_ERROR;
                        end else begin
                            state     <= IDLE;
                            hreadyout <= 1'b1;
                            if (!pwrite) begin
                                hrdata <= prdata;
                            end
                        end
                    end else if (timeout) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= ERR1;
                        hresp   <= HRESP_ERROR;
                    end
                end
                ERR1: begin
                    // Second cycle of the two-cycle AHB ERROR response.
                    hreadyout <= 1'b1;
                    state     <= ERR2;
                end
                ERR2: begin
                    hresp <= HRESP_OKAY;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed self-checking bench for ahb2apb_bridge (TIMEOUT=16 main instance, TIMEOUT=0 second).
module tb_ahb2apb_bridge;

    logic        hclk;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic        hready;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    logic        hreadyout, hresp, pwrite, psel, penable;
    logic [31:0] hrdata, paddr, pwdata;
    logic        z_hreadyout, z_hresp, z_pwrite, z_psel, z_penable;
    logic [31:0] z_hrdata, z_paddr, z_pwdata;

    int vectors;
    int miscompares;

    ahb2apb_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hready    (hready),
        .hwdata    (hwdata),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .hrdata    (hrdata),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    ahb2apb_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (0)
    ) dut_notimeout (
        .hclk      (hclk),
        .hreset    (hreset),
        .hsel      (hsel),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .htrans    (htrans),
        .hready    (hready),
        .hwdata    (hwdata),
        .hreadyout (z_hreadyout),
        .hresp     (z_hresp),
        .hrdata    (z_hrdata),
        .paddr     (z_paddr),
        .pwrite    (z_pwrite),
        .psel      (z_psel),
        .penable   (z_penable),
        .pwdata    (z_pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    // Present an AHB address phase.
    task automatic start_xfer(input logic [31:0] addr, input logic wr);
        hsel   = 1'b1;
        hready = 1'b1;
        haddr  = addr;
        hwrite = wr;
        htrans = 2'b10;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        start_xfer(32'h0000_0004, 1'b0);
        step();
        step();
        vectors++; if (psel !== 1'b0) begin miscompares++;
            $display("FAIL rst_psel: got %0h exp 0", psel); end
        vectors++; if (penable !== 1'b0) begin miscompares++;
            $display("FAIL rst_penable: got %0h exp 0", penable); end
        vectors++; if (hreadyout !== 1'b1) begin miscompares++;
            $display("FAIL rst_hreadyout: got %0h exp 1", hreadyout); end
        vectors++; if (hresp !== 1'b0) begin miscompares++;
            $display("FAIL rst_hresp: got %0h exp 0", hresp); end
        vectors++; if (paddr !== 32'h0) begin miscompares++;
            $display("FAIL rst_paddr: got %h exp 0", paddr); end
        vectors++; if (pwdata !== 32'h0) begin miscompares++;
            $display("FAIL rst_pwdata: got %h exp 0", pwdata); end
        vectors++; if (hrdata !== 32'h0) begin miscompares++;
            $display("FAIL rst_hrdata: got %h exp 0", hrdata); end
        vectors++; if (pwrite !== 1'b0) begin miscompares++;
            $display("FAIL rst_pwrite: got %0h exp 0", pwrite); end
        vectors++; if (z_hreadyout !== 1'b1) begin miscompares++;
            $display("FAIL rst_z_hreadyout: got %0h exp 1", z_hreadyout); end
        htrans = 2'b00;
        hreset = 1'b0;
        step();
    endtask

    task automatic test_ignored();
        logic [1:0] trans_tbl [3];
        logic       sel_tbl   [3];
        trans_tbl = '{2'b00, 2'b01, 2'b10};
        sel_tbl   = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            hsel   = sel_tbl[i];
            hready = 1'b1;
            htrans = trans_tbl[i];
            haddr  = 32'h0000_0100;
            step();
            vectors++; if (hreadyout !== 1'b1 || psel !== 1'b0) begin miscompares++;
                $display("FAIL ign_%0d: got hreadyout=%0h psel=%0h exp 1/0", i, hreadyout, psel);
            end
        end
        // hready low from the bus means no address phase is taking place.
        start_xfer(32'h0000_0100, 1'b0);
        hready = 1'b0;
        step();
        vectors++; if (hreadyout !== 1'b1 || psel !== 1'b0) begin miscompares++;
            $display("FAIL ign_hready0: got hreadyout=%0h psel=%0h exp 1/0", hreadyout, psel);
        end
        hready = 1'b1;
        htrans = 2'b00;
        vectors++; if (hresp !== 1'b0) begin miscompares++;
            $display("FAIL ign_hresp: got %0h exp 0", hresp); end
    endtask

    task automatic test_read();
        pready = 1'b1;
        prdata = 32'hDEAD_BEEF;
        start_xfer(32'h0000_0010, 1'b0);
        step();  // T1: SETUP
        htrans = 2'b00;
        vectors++; if ({hreadyout, psel, penable} !== 3'b010) begin miscompares++;
            $display("FAIL rd_t1: got rdy/psel/pen=%b exp 010", {hreadyout, psel, penable}); end
        vectors++; if (paddr !== 32'h10 || pwrite !== 1'b0) begin miscompares++;
            $display("FAIL rd_t1_addr: got %h/%0h exp 00000010/0", paddr, pwrite); end
        step();  // T2: ACCESS
        vectors++; if ({hreadyout, psel, penable} !== 3'b011) begin miscompares++;
            $display("FAIL rd_t2: got rdy/psel/pen=%b exp 011", {hreadyout, psel, penable}); end
        step();  // T3: done
        vectors++; if ({hreadyout, psel, penable} !== 3'b100) begin miscompares++;
            $display("FAIL rd_t3: got rdy/psel/pen=%b exp 100", {hreadyout, psel, penable}); end
        vectors++; if (hrdata !== 32'hDEAD_BEEF || hresp !== 1'b0) begin miscompares++;
            $display("FAIL rd_t3_data: got %h/%0h exp deadbeef/0", hrdata, hresp); end
    endtask

    task automatic test_write();
        pready = 1'b1;
        prdata = 32'h1234_5678;
        hwdata = 32'h1111_1111;
        start_xfer(32'h0000_0024, 1'b1);
        step();  // T1: WLATCH
        htrans = 2'b00;
        hwdata = 32'hA5A5_0001;
        vectors++; if ({hreadyout, psel, penable} !== 3'b000) begin miscompares++;
            $display("FAIL wr_t1: got rdy/psel/pen=%b exp 000", {hreadyout, psel, penable}); end
        step();  // T2: SETUP
        hwdata = 32'h0000_0000;
        vectors++; if ({psel, penable} !== 2'b10 || pwdata !== 32'hA5A5_0001) begin miscompares++;
            $display("FAIL wr_t2: got psel/pen=%b pwdata=%h exp 10 a5a50001",
                     {psel, penable}, pwdata); end
        vectors++; if (paddr !== 32'h24 || pwrite !== 1'b1) begin miscompares++;
            $display("FAIL wr_t2_addr: got %h/%0h exp 00000024/1", paddr, pwrite); end
        step();  // T3: ACCESS
        vectors++; if ({hreadyout, psel, penable} !== 3'b011 || pwdata !== 32'hA5A5_0001) begin
            miscompares++;
            $display("FAIL wr_t3: got rdy/psel/pen=%b pwdata=%h exp 011 a5a50001",
                     {hreadyout, psel, penable}, pwdata); end
        step();  // T4: done
        vectors++; if ({hreadyout, psel, penable, hresp} !== 4'b1000) begin miscompares++;
            $display("FAIL wr_t4: got rdy/psel/pen/resp=%b exp 1000",
                     {hreadyout, psel, penable, hresp}); end
        vectors++; if (hrdata !== 32'hDEAD_BEEF) begin miscompares++;
            $display("FAIL wr_hrdata_hold: got %h exp deadbeef", hrdata); end
    endtask

    task automatic test_wait_states();
        int pen_cycles;
        pen_cycles = 0;
        pready = 1'b0;
        prdata = 32'hCAFE_0003;
        start_xfer(32'h0000_0030, 1'b0);
        step();  // SETUP
        htrans = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();  // ACCESS cycles 1..4
            if (penable === 1'b1) pen_cycles++;
            vectors++; if (hreadyout !== 1'b0) begin miscompares++;
                $display("FAIL ws_rdy_%0d: got %0h exp 0", i, hreadyout); end
        end
        pready = 1'b1;
        step();
        vectors++; if (pen_cycles != 4) begin miscompares++;
            $display("FAIL ws_pen_cycles: got %0d exp 4", pen_cycles); end
        vectors++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || penable !== 1'b0) begin
            miscompares++;
            $display("FAIL ws_done: got rdy/resp/pen=%b exp 100", {hreadyout, hresp, penable});
        end
        vectors++; if (hrdata !== 32'hCAFE_0003) begin miscompares++;
            $display("FAIL ws_hrdata: got %h exp cafe0003", hrdata); end
    endtask

    task automatic test_slverr();
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hBAD0_BAD0;
        start_xfer(32'h0000_0040, 1'b0);
        step();  // SETUP
        htrans = 2'b00;
        step();  // ACCESS
        step();  // ERR1
        vectors++; if ({hreadyout, hresp, psel, penable} !== 4'b0100) begin miscompares++;
            $display("FAIL err1: got rdy/resp/psel/pen=%b exp 0100",
                     {hreadyout, hresp, psel, penable}); end
        vectors++; if (hrdata !== 32'hCAFE_0003) begin miscompares++;
            $display("FAIL err_hrdata_hold: got %h exp cafe0003", hrdata); end
        // Transfers offered during ERR1 and ERR2 must be dropped.
        start_xfer(32'h0000_0044, 1'b0);
        step();  // ERR2
        vectors++; if ({hreadyout, hresp, psel} !== 3'b110) begin miscompares++;
            $display("FAIL err2: got rdy/resp/psel=%b exp 110", {hreadyout, hresp, psel}); end
        step();  // IDLE
        htrans  = 2'b00;
        pslverr = 1'b0;
        vectors++; if ({hreadyout, hresp, psel} !== 3'b100) begin miscompares++;
            $display("FAIL err_idle: got rdy/resp/psel=%b exp 100", {hreadyout, hresp, psel}); end
        step();
        vectors++; if (psel !== 1'b0 || hreadyout !== 1'b1) begin miscompares++;
            $display("FAIL err_ignored: got psel=%0h rdy=%0h exp 0/1", psel, hreadyout); end
    endtask

    task automatic test_timeout();
        int access_seen;
        access_seen = 0;
        pready = 1'b0;
        start_xfer(32'h0000_0050, 1'b0);
        step();  // SETUP
        htrans = 2'b00;
        step();  // ACCESS cycle 1
        for (int i = 0; i < 15; i++) begin
            if (penable === 1'b1) access_seen++;
            step();
        end
        if (penable === 1'b1) access_seen++;
        vectors++; if (access_seen != 16) begin miscompares++;
            $display("FAIL to_access_cycles: got %0d exp 16", access_seen); end
        step();  // ERR1 after 16 waiting ACCESS cycles
        vectors++; if ({psel, penable, hreadyout, hresp} !== 4'b0001) begin miscompares++;
            $display("FAIL to_err1: got psel/pen/rdy/resp=%b exp 0001",
                     {psel, penable, hreadyout, hresp}); end
        vectors++; if ({z_psel, z_penable} !== 2'b11) begin miscompares++;
            $display("FAIL to0_early: got psel/pen=%b exp 11", {z_psel, z_penable}); end
        for (int i = 0; i < 84; i++) step();
        vectors++; if ({z_psel, z_penable, z_hreadyout, z_hresp} !== 4'b1100) begin
            miscompares++;
            $display("FAIL to0_100: got psel/pen/rdy/resp=%b exp 1100",
                     {z_psel, z_penable, z_hreadyout, z_hresp}); end
        vectors++; if ({hreadyout, hresp, psel} !== 3'b100) begin miscompares++;
            $display("FAIL to_recover: got rdy/resp/psel=%b exp 100", {hreadyout, hresp, psel});
        end
    endtask

    task automatic test_reset_mid();
        pready = 1'b0;
        start_xfer(32'h0000_0058, 1'b0);
        step();  // SETUP
        htrans = 2'b00;
        step();  // ACCESS
        vectors++; if (penable !== 1'b1) begin miscompares++;
            $display("FAIL rm_access: got %0h exp 1", penable); end
        // Reset wins even with a valid transfer and pready on the bus.
        hreset = 1'b1;
        pready = 1'b1;
        start_xfer(32'h0000_005C, 1'b0);
        step();
        vectors++; if ({psel, penable, hreadyout, hresp} !== 4'b0010) begin miscompares++;
            $display("FAIL rm_main: got psel/pen/rdy/resp=%b exp 0010",
                     {psel, penable, hreadyout, hresp}); end
        vectors++; if ({z_psel, z_penable, z_hreadyout, z_hresp} !== 4'b0010) begin
            miscompares++;
            $display("FAIL rm_z: got psel/pen/rdy/resp=%b exp 0010",
                     {z_psel, z_penable, z_hreadyout, z_hresp}); end
        hreset = 1'b0;
        htrans = 2'b00;
        step();
        vectors++; if ({psel, hreadyout, hresp} !== 3'b010) begin miscompares++;
            $display("FAIL rm_idle_ign: got psel/rdy/resp=%b exp 010", {psel, hreadyout, hresp});
        end
    endtask

    task automatic test_back_to_back();
        pready = 1'b1;
        prdata = 32'h1111_2222;
        start_xfer(32'h0000_0060, 1'b0);
        step();  // SETUP
        htrans = 2'b00;
        step();  // ACCESS
        step();  // read done, hreadyout high
        vectors++; if (hreadyout !== 1'b1 || hrdata !== 32'h1111_2222) begin miscompares++;
            $display("FAIL b2b_rd: got rdy=%0h hrdata=%h exp 1 11112222", hreadyout, hrdata);
        end
        start_xfer(32'h0000_0064, 1'b1);
        step();  // accepted straight away: WLATCH
        htrans = 2'b00;
        hwdata = 32'h0BAD_F00D;
        vectors++; if (hreadyout !== 1'b0) begin miscompares++;
            $display("FAIL b2b_accept: got rdy=%0h exp 0", hreadyout); end
        step();  // SETUP
        vectors++; if (psel !== 1'b1 || paddr !== 32'h64 || pwdata !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL b2b_setup: got psel=%0h paddr=%h pwdata=%h exp 1 00000064 0badf00d",
                     psel, paddr, pwdata); end
        step();  // ACCESS
        step();  // done
        vectors++; if ({hreadyout, hresp, psel, penable} !== 4'b1000) begin miscompares++;
            $display("FAIL b2b_wr_done: got rdy/resp/psel/pen=%b exp 1000",
                     {hreadyout, hresp, psel, penable}); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        hreset  = 1'b1;
        hsel    = 1'b0;
        haddr   = '0;
        hwrite  = 1'b0;
        htrans  = 2'b00;
        hready  = 1'b1;
        hwdata  = '0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;

        test_reset();
        test_ignored();
        test_read();
        test_write();
        test_wait_states();
        test_slverr();
        test_timeout();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound the whole run in case the bench itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion exp finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
